// File: rtl/uk101_pkg.sv
// rtl/uk101_pkg.sv - shared types and constants for the UK101 ascii loader
package uk101_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} ser_state_t;

  localparam int BAUD_9600 = 9600;
  localparam int BAUD_300  = 300;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_SUB = 8'h1A;

  // LF is implied by the CR gap and SUB is a DOS end-of-file marker; neither reaches BASIC.
  function automatic logic is_dropped(input logic [7:0] b);
    return (b == ASCII_LF) || (b == ASCII_SUB);
  endfunction

endpackage

// File: rtl/ascii_load_arbiter_if.sv
// rtl/ascii_load_arbiter_if.sv - hps_io download bus into the ascii load arbiter
interface ascii_load_arbiter_if;

  logic       ioctl_download;
  logic [7:0] ioctl_index;
  logic       ioctl_wr;
  logic [7:0] ioctl_data;
  logic       ioctl_wait;

  modport master (output ioctl_download, ioctl_index, ioctl_wr, ioctl_data, input ioctl_wait);
  modport slave  (input ioctl_download, ioctl_index, ioctl_wr, ioctl_data, output ioctl_wait);

endinterface

// File: rtl/uk101_byte_fifo.sv
// rtl/uk101_byte_fifo.sv - show-ahead byte FIFO with synchronous flush
module uk101_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full FIFO is silently ignored.
  assign do_push = push && (count_q != (AW+1)'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ascii_load_arbiter.sv
// rtl/ascii_load_arbiter.sv - buffers OSD ascii bytes and re-serialises them as 8N1 into uk101 rxd
module ascii_load_arbiter
  import uk101_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int FIFO_DEPTH  = 16,
  parameter int GAP_BITS    = 2,
  parameter int CR_GAP_BITS = 200
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 load_from,
  input  logic                 baud_sel,
  ascii_load_arbiter_if.slave  ioctl,
  input  logic                 uart_rxd,
  output logic                 acia_rxd,
  output logic                 busy
);

  localparam int DIV_W = $clog2(CLK_HZ / BAUD_300);
  localparam int GAP_W = $clog2(CR_GAP_BITS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DIV_W-1:0] RELOAD_9600 = DIV_W'(CLK_HZ / BAUD_9600 - 1);
  localparam logic [DIV_W-1:0] RELOAD_300  = DIV_W'(CLK_HZ / BAUD_300 - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_BITS - 1);
  localparam logic [GAP_W-1:0] CR_GAP_LAST = GAP_W'(CR_GAP_BITS - 1);

  ser_state_t       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, reload_q, reload_d, frame_reload;
  logic [2:0]       bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       byte_q, byte_d;
  logic             wait_q, wait_d;

  logic             push, pop, tx_line;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] count;

  assign push = !load_from && ioctl.ioctl_download && ioctl.ioctl_wr &&
                (ioctl.ioctl_index == 8'd0) && !is_dropped(ioctl.ioctl_data);

  uk101_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (load_from),
    .din   (ioctl.ioctl_data),
    .dout  (fifo_dout),
    .count (count)
  );

  // Two entries of headroom absorb the write that lands while the registered flag updates.
  assign wait_d       = (count >= CNT_W'(FIFO_DEPTH - 2)) && !load_from;
  assign frame_reload = baud_sel ? RELOAD_300 : RELOAD_9600;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      reload_q <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      byte_q   <= '0;
      wait_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      reload_q <= reload_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      byte_q   <= byte_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    reload_d = reload_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    byte_d   = byte_q;
    if (load_from) begin
      state_d = IDLE;
      div_d   = '0;
      bit_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            byte_d   = fifo_dout;
            reload_d = frame_reload;
            div_d    = frame_reload;
            bit_d    = '0;
            state_d  = START;
          end
        end
        START: begin
          if (div_q == '0) begin
            div_d   = reload_q;
            state_d = DATA;
          end else div_d = div_q - 1'b1;
        end
        DATA: begin
          if (div_q == '0) begin
            div_d = reload_q;
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 1'b1;
          end else div_d = div_q - 1'b1;
        end
        STOP: begin
          if (div_q == '0) begin
            div_d   = reload_q;
            gap_d   = (byte_q == ASCII_CR) ? CR_GAP_LAST : GAP_LAST;
            state_d = GAP;
          end else div_d = div_q - 1'b1;
        end
        GAP: begin
          if (div_q == '0) begin
            if (gap_q == '0) state_d = IDLE;
            else begin
              gap_d = gap_q - 1'b1;
              div_d = reload_q;
            end
          end else div_d = div_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    pop = (state_q == IDLE) && !load_from && (count != '0);
    case (state_q)
      START:   tx_line = 1'b0;
      DATA:    tx_line = byte_q[bit_q];
      default: tx_line = 1'b1;
    endcase
  end

  assign acia_rxd         = load_from ? uart_rxd : tx_line;
  assign busy             = (count != '0) || (state_q != IDLE);
  assign ioctl.ioctl_wait = wait_q;

endmodule

// File: tb/tb_ascii_load_arbiter.sv
// tb/tb_ascii_load_arbiter.sv - directed bench for ascii_load_arbiter at CLK_HZ=96000
`timescale 1ns/1ps
module tb_ascii_load_arbiter;

  logic clk_sys = 1'b0;
  logic reset, load_from, baud_sel, uart_rxd, acia_rxd, busy;

  ascii_load_arbiter_if ioctl_bus();

  ascii_load_arbiter #(.CLK_HZ(96_000)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .load_from (load_from),
    .baud_sel  (baud_sel),
    .ioctl     (ioctl_bus),
    .uart_rxd  (uart_rxd),
    .acia_rxd  (acia_rxd),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line receiver: samples each bit at its centre, rx_period clocks per bit.
  int         rx_period = 10;
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_q[$];
  int         rx_start[$];

  always @(negedge clk_sys) begin
    cyc++;
    if (reset || load_from) rx_busy = 1'b0;
    else if (!rx_busy) begin
      if (acia_rxd === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
        rx_start.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 9 * rx_period + rx_period / 2) begin
        check("stop_bit", 32'(acia_rxd), 1);
        rx_q.push_back(rx_sh);
        rx_busy = 1'b0;
      end else if ((rx_cnt % rx_period) == rx_period / 2 && rx_cnt > rx_period)
        rx_sh = {acia_rxd, rx_sh[7:1]};
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic write_byte(input logic [7:0] b);
    ioctl_bus.ioctl_wr   = 1'b1;
    ioctl_bus.ioctl_data = b;
    tick();
    ioctl_bus.ioctl_wr   = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin tick(); t++; end
    check(tag, 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t;
    t = 0;
    while (busy && t < budget) begin tick(); t++; end
    check(tag, 32'(busy), 0);
  endtask

  logic [7:0] ch;
  logic       v;

  initial begin
    int sent, stall_at, guard;
    reset = 1'b1; load_from = 1'b0; baud_sel = 1'b0; uart_rxd = 1'b1;
    ioctl_bus.ioctl_download = 1'b1; ioctl_bus.ioctl_index = 8'd0;
    ioctl_bus.ioctl_wr = 1'b0; ioctl_bus.ioctl_data = 8'd0;
    tick(2);
    check("rst_acia", 32'(acia_rxd), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_wait", 32'(ioctl_bus.ioctl_wait), 0);
    reset = 1'b0;
    tick();

    // 1: single 0x41 frame, bit by bit
    ch = 8'h41;
    write_byte(ch);
    check("t1_pre_start", 32'(acia_rxd), 1);
    check("t1_busy", 32'(busy), 1);
    tick();
    for (int i = 0; i < 10; i++) begin check("t1_start", 32'(acia_rxd), 0); tick(); end
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 10; i++) begin check("t1_data", 32'(acia_rxd), 32'(ch[b])); tick(); end
    for (int i = 0; i < 30; i++) begin check("t1_stop_gap", 32'(acia_rxd), 1); tick(); end
    check("t1_idle", 32'(busy), 0);
    check("t1_rx_n", 32'(rx_q.size()), 1);
    check("t1_rx_byte", 32'(rx_q[0]), 32'h41);
    rx_q.delete(); rx_start.delete();

    // 2: LF dropped, long gap after CR
    write_byte(8'h41); write_byte(8'h0D); write_byte(8'h0A); write_byte(8'h42);
    wait_rx(3, 3000, "t2_rx_wait");
    wait_idle(3000, "t2_idle");
    check("t2_rx_n", 32'(rx_q.size()), 3);
    check("t2_b0", 32'(rx_q[0]), 32'h41);
    check("t2_b1", 32'(rx_q[1]), 32'h0D);
    check("t2_b2", 32'(rx_q[2]), 32'h42);
    check("t2_char_gap", 32'(rx_start[1] - rx_start[0]), 121);
    check("t2_cr_gap", 32'(rx_start[2] - rx_start[1]), 2101);
    rx_q.delete(); rx_start.delete();

    // 3: burst of 20 writes honouring ioctl_wait
    sent = 0; stall_at = -1; guard = 0;
    while (sent < 20 && guard < 10000) begin
      if (ioctl_bus.ioctl_wait) begin
        if (stall_at < 0) stall_at = sent;
        ioctl_bus.ioctl_wr = 1'b0;
      end else begin
        ioctl_bus.ioctl_wr   = 1'b1;
        ioctl_bus.ioctl_data = 8'(48 + sent);
        sent++;
      end
      tick();
      guard++;
    end
    ioctl_bus.ioctl_wr = 1'b0;
    check("t3_sent", 32'(sent), 20);
    check("t3_stall_at", 32'(stall_at), 16);
    wait_idle(6000, "t3_idle");
    check("t3_wait_low", 32'(ioctl_bus.ioctl_wait), 0);
    check("t3_rx_n", 32'(rx_q.size()), 20);
    for (int i = 0; i < 20; i++) check("t3_byte", 32'(rx_q[i]), 32'(8'(48 + i)));
    rx_q.delete(); rx_start.delete();

    // 4: UART pin path
    load_from = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      v = 1'(i % 2);
      uart_rxd = v;
      #1;
      check("t4_mirror", 32'(acia_rxd), 32'(v));
      tick();
    end
    write_byte(8'h55);
    check("t4_busy", 32'(busy), 0);
    check("t4_wait", 32'(ioctl_bus.ioctl_wait), 0);
    uart_rxd = 1'b1;
    load_from = 1'b0;
    tick(3);
    check("t4_dropped", 32'(busy), 0);
    check("t4_line", 32'(acia_rxd), 1);

    // 5: baud change mid-frame applies to the next frame
    rx_q.delete(); rx_start.delete();
    rx_period = 10;
    write_byte(8'h41); write_byte(8'h55);
    tick(30);
    baud_sel = 1'b1;
    wait_rx(1, 200, "t5_rx1_wait");
    rx_period = 320;
    wait_rx(2, 5000, "t5_rx2_wait");
    check("t5_b0", 32'(rx_q[0]), 32'h41);
    check("t5_b1", 32'(rx_q[1]), 32'h55);
    check("t5_spacing", 32'(rx_start[1] - rx_start[0]), 121);
    wait_idle(2000, "t5_idle");
    baud_sel = 1'b0;
    rx_period = 10;

    // 6a: async reset during DATA
    write_byte(8'h41);
    tick(40);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_acia", 32'(acia_rxd), 1);
    check("t6_rst_busy", 32'(busy), 0);
    tick();
    reset = 1'b0;
    tick(5);
    check("t6_post_rst_busy", 32'(busy), 0);
    check("t6_post_rst_acia", 32'(acia_rxd), 1);

    // 6b: load_from raised mid-frame aborts and flushes
    rx_q.delete(); rx_start.delete();
    write_byte(8'h41); write_byte(8'h42);
    tick(40);
    uart_rxd = 1'b0;
    load_from = 1'b1;
    #1;
    check("t6_lf_mirror", 32'(acia_rxd), 0);
    tick();
    check("t6_lf_busy", 32'(busy), 0);
    uart_rxd = 1'b1;
    load_from = 1'b0;
    tick(20);
    check("t6_flushed", 32'(busy), 0);
    check("t6_line", 32'(acia_rxd), 1);
    check("t6_rx_n", 32'(rx_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
